mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one single-port memory between a CPU and an I/O requester.
// Every transaction takes three cycles: IDLE (arbitrate and latch), ACCESS (strobe), RESPOND (ack).
module mem_bus_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_ack,
    output logic [DW-1:0] io_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata valid and holds it until its ack;
    // operands are captured only at grant, and ack is a single-cycle pulse in RESPOND.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_we;
    logic          r_gnt_io;
    logic          r_last_io;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_io_rdata;
    logic          w_any_req;
    logic          w_pick_io;
    logic          w_sel_we;

    assign w_any_req = cpu_req | io_req;
    assign w_pick_io = io_req & (~cpu_req | ~r_last_io);
    assign w_sel_we  = w_pick_io ? io_we : cpu_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = w_any_req ? ACCESS : IDLE;
            ACCESS:  w_next_state = RESPOND;
            RESPOND: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_gnt_io    <= 1'b0;
            r_last_io   <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            cpu_ack     <= 1'b0;
            io_ack      <= 1'b0;
            busy        <= 1'b0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= 1'b0;
            io_ack    <= 1'b0;
            busy      <= (w_next_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt_io  <= w_pick_io;
                        r_last_io <= w_pick_io;
                        r_we      <= w_sel_we;
                        mem_addr  <= w_pick_io ? io_addr : cpu_addr;
                        mem_wdata <= w_pick_io ? io_wdata : cpu_wdata;
                        mem_read  <= ~w_sel_we;
                        mem_write <= w_sel_we;
                    end
                end
                ACCESS: begin
                    cpu_ack <= ~r_gnt_io;
                    io_ack  <= r_gnt_io;
                end
                RESPOND: begin
                    // Keep the read word so rdata holds it through later writes.
                    if (!r_we) begin
                        if (r_gnt_io) r_io_rdata <= mem_rdata;
                        else          r_cpu_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory data only arrives in RESPOND, so the ack cycle forwards it; the selects are registered.
    assign cpu_rdata = (cpu_ack && !r_we) ? mem_rdata : r_cpu_rdata;
    assign io_rdata  = (io_ack && !r_we) ? mem_rdata : r_io_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, arbitration and reset sequences,
// and an ack scoreboard fed by an expected queue.
module tb_mem_bus_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_ack;
    logic [DW-1:0] io_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    dbg_state;

    mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // single-port memory with registered read data
    logic [DW-1:0] mem_model [4096];
    always @(posedge clk) begin
        if (mem_write) mem_model[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem_model[mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;
    logic [DW:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // scoreboard: every ack pops one {is_io, rdata} record
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_ack", {31'd0, cpu_ack & io_ack}, 32'd0);
            chk("one_strobe", {31'd0, mem_read & mem_write}, 32'd0);
            if (cpu_ack || io_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {31'd0, io_ack}, 32'hFFFF_FFFF);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("ack_record", {15'd0, io_ack, (io_ack ? io_rdata : cpu_rdata)}, {15'd0, e});
                end
            end
        end
    end

    // driver tasks
    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic          use_io;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    task automatic do_single(input vec_t v, input int idx);
        int  waited;
        bit  got;
        if (v.use_io) begin
            io_req = 1'b1; io_we = v.we; io_addr = v.addr; io_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        exp_q.push_back({v.use_io, v.exp_rd});
        @(negedge clk);
        chk($sformatf("v%0d_mem_read", idx), {31'd0, mem_read}, {31'd0, ~v.we});
        chk($sformatf("v%0d_mem_write", idx), {31'd0, mem_write}, {31'd0, v.we});
        chk($sformatf("v%0d_mem_addr", idx), {20'd0, mem_addr}, {20'd0, v.addr});
        if (v.we) chk($sformatf("v%0d_mem_wdata", idx), {16'd0, mem_wdata}, {16'd0, v.wdata});
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 6) begin
            @(negedge clk);
            waited++;
            got = cpu_ack | io_ack;
        end
        chk($sformatf("v%0d_ack_latency", idx), waited, 1);
        cpu_req = 1'b0;
        io_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_contention();
        int acks = 0;
        int last_cyc = 0;
        int waited = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
        io_req  = 1'b1; io_we  = 1'b0; io_addr  = 12'h000;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 16'h1234});
            exp_q.push_back({1'b1, 16'h0000});
        end
        while (acks < 4 && waited < 30) begin
            @(negedge clk);
            waited++;
            if (cpu_ack || io_ack) begin
                chk($sformatf("rr_order_%0d", acks), {31'd0, io_ack}, acks % 2);
                if (acks > 0) chk($sformatf("rr_spacing_%0d", acks), cyc - last_cyc, 3);
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin
                    cpu_req = 1'b0;
                    io_req  = 1'b0;
                end
            end
        end
        chk("rr_ack_count", acks, 4);
        cpu_req = 1'b0;
        io_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_late_change();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005; cpu_wdata = 16'h0000;
        exp_q.push_back({1'b0, 16'h1234});
        @(negedge clk);
        chk("late_mem_addr", {20'd0, mem_addr}, 32'h005);
        chk("late_mem_read", {31'd0, mem_read}, 32'd1);
        cpu_addr = 12'h0AA; cpu_we = 1'b1; cpu_wdata = 16'hDEAD; cpu_req = 1'b0;
        @(negedge clk);
        chk("late_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("late_addr_held", {20'd0, mem_addr}, 32'h005);
        chk("late_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        chk("late_idle_busy", {31'd0, busy}, 32'd0);
        chk("late_no_reack", {31'd0, cpu_ack}, 32'd0);
        chk("late_no_write", {16'd0, mem_model[12'h0AA]}, 32'd0);
    endtask

    task automatic run_reset_in_access();
        int  waited = 0;
        bit  got = 1'b0;
        io_req = 1'b1; io_we = 1'b0; io_addr = 12'hFFF;
        @(negedge clk);
        chk("rst_access_state", {30'd0, dbg_state}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_no_ack", {30'd0, cpu_ack, io_ack}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        exp_q.push_back({1'b1, 16'hBEEF});
        while (!got && waited < 8) begin
            @(negedge clk);
            waited++;
            got = io_ack;
        end
        chk("rst_pending_latency", waited, 2);
        io_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 12'hFFF, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b1, 12'hABC, 16'h5A5A, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 12'hABC, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b1, 12'h000, 16'h0001, 16'h5A5A};
        vecs[6] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'h0001};
        vecs[7] = '{1'b1, 1'b0, 12'h005, 16'h0000, 16'h1234};
        vecs[8] = '{1'b0, 1'b1, 12'h123, 16'hFFFF, 16'h0001};

        for (int i = 0; i < 4096; i++) mem_model[i] = '0;
        mem_model[12'h005] = 16'h1234;
        mem_rdata = '0;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;

        hold_reset();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_acks", {30'd0, cpu_ack, io_ack}, 32'd0);
        chk("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("reset_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("reset_io_rdata", {16'd0, io_rdata}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        run_contention();

        hold_reset();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) do_single(vecs[i], i);

        run_late_change();
        run_reset_in_access();

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
